// File: rtl/load_store_unit.sv
// Load/store unit: turns one decode-stage memory request into a single bus
// transaction, aligning store data, extending load data, and bounding bus waits.
module load_store_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  byte_en,
  input  logic        us,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misaligned,
  output logic        fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  state_t        state, state_next;
  size_t         req_size, size_q;
  logic [3:0]    size_be;
  logic          req, mis, accept, timeout_hit;
  logic          us_q;
  logic [1:0]    off_q;
  logic [CW-1:0] wait_cnt;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_ext;

  // Request decode; unknown byte_en patterns fall through to a word access.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    req_size = SZ_WORD;
    size_be  = 4'b1111;
    case (byte_en)
      4'b0001: begin req_size = SZ_BYTE; size_be = 4'b0001; end
      4'b0011: begin req_size = SZ_HALF; size_be = 4'b0011; end
      default: ;
    endcase
  end

  assign req         = mem_read | mem_write;
  assign mis         = ((req_size == SZ_HALF) && addr[0]) ||
                       ((req_size == SZ_WORD) && (addr[1:0] != 2'b00));
  assign accept      = req && !mis;
  assign timeout_hit = (wait_cnt == CW'(TIMEOUT - 1)) && !bus_ack;

  // Load extraction from the captured lane offset and size.
  assign ld_byte = bus_rdata[{off_q, 3'b000} +: 8];
  assign ld_half = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];

  always_comb begin
    ld_ext = bus_rdata;
    case (size_q)
      SZ_BYTE: ld_ext = {{24{~us_q & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_ext = {{16{~us_q & ld_half[15]}}, ld_half};
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = BUS;
      BUS:     if (bus_ack || timeout_hit) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs: stall is combinational so an accepted request holds decode at once.
  always_comb begin
    stall = 1'b0;
    if (rst_n) stall = ((state == IDLE) && accept) || (state == BUS);
  end

  // Bus request registers, wait counter and load result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata      <= '0;
      misaligned <= 1'b0;
      fault      <= 1'b0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_be     <= '0;
      bus_wdata  <= '0;
      wait_cnt   <= '0;
      us_q       <= 1'b0;
      off_q      <= '0;
      size_q     <= SZ_WORD;
    end else begin
      misaligned <= 1'b0;
      fault      <= 1'b0;
      case (state)
        IDLE: begin
          if (req && mis) begin
            misaligned <= 1'b1;
          end else if (accept) begin
            bus_req   <= 1'b1;
            bus_we    <= !mem_read;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_be    <= size_be << addr[1:0];
            bus_wdata <= wdata << {addr[1:0], 3'b000};
            us_q      <= us;
            off_q     <= addr[1:0];
            size_q    <= req_size;
            wait_cnt  <= '0;
          end
        end
        BUS: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (!bus_we) rdata <= ld_ext;
          end else if (timeout_hit) begin
            // A timed-out access leaves a clean zero rather than stale data.
            bus_req <= 1'b0;
            fault   <= 1'b1;
            rdata   <= '0;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized
// accesses checked against a transaction-level reference model.
module tb_load_store_unit;
  localparam int TO = 4;

  logic        clk, rst_n;
  logic        mem_read, mem_write, us, bus_ack;
  logic [3:0]  byte_en;
  logic [31:0] addr, wdata, bus_rdata;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic        stall, misaligned, fault, bus_req, bus_we;
  logic [3:0]  bus_be;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_rdata;

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .byte_en(byte_en), .us(us), .addr(addr), .wdata(wdata), .rdata(rdata),
    .stall(stall), .misaligned(misaligned), .fault(fault), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic int size_bytes(input logic [3:0] be);
    if (be == 4'b0001) return 1;
    if (be == 4'b0011) return 2;
    return 4;
  endfunction

  // Reference load: pick n bytes starting at byte offset, then extend.
  function automatic logic [31:0] model_load(input logic [31:0] data, input int off,
                                             input int n, input bit uns);
    logic [31:0] v, mask;
    if (n == 4) return data;
    mask = (32'd1 << (8 * n)) - 32'd1;
    v = (data >> (8 * off)) & mask;
    if (!uns && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    addr      = $urandom;
    wdata     = $urandom;
    byte_en   = 4'($urandom);
    us        = 1'($urandom);
  endtask

  // One full access; ack_dly = BUS cycle index carrying the ack (>= TO means none).
  task automatic do_access(input bit rd, input bit wr, input logic [3:0] be, input bit uns,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int ack_dly, input logic [31:0] rdat);
    int n, off, stall_cnt, exp_stall;
    bit timed_out;
    logic [31:0] exp_addr, exp_wd;
    logic [3:0]  exp_be;
    n   = size_bytes(be);
    off = int'(a[1:0]);
    mem_read = rd; mem_write = wr; byte_en = be; us = uns; addr = a; wdata = wd;
    #1;
    if ((off % n) != 0) begin
      check("mis_stall", stall, 0);
      tick();
      idle_inputs();
      check("mis_pulse", misaligned, 1);
      check("mis_req", bus_req, 0);
      check("mis_rdata", rdata, exp_rdata);
      tick();
      check("mis_clear", misaligned, 0);
      check("mis_req2", bus_req, 0);
      return;
    end
    check("idle_stall", stall, 1);
    stall_cnt = 1;
    tick();
    idle_inputs();
    exp_addr = {a[31:2], 2'b00};
    exp_be   = 4'(((1 << n) - 1) << off);
    exp_wd   = wd << (8 * off);
    timed_out = 1'b0;
    for (int k = 0; k < TO; k++) begin
      check("bus_req", bus_req, 1);
      check("bus_addr", bus_addr, exp_addr);
      check("bus_be", bus_be, exp_be);
      check("bus_we", bus_we, !rd);
      if (!rd) check("bus_wdata", bus_wdata, exp_wd);
      check("bus_fault", fault, 0);
      if (stall) stall_cnt++;
      bus_ack   = (k == ack_dly);
      bus_rdata = (k == ack_dly) ? rdat : $urandom;
      tick();
      bus_ack = 1'b0;
      if (k == ack_dly) break;
      if (k == TO - 1) timed_out = 1'b1;
    end
    if (timed_out)  exp_rdata = '0;
    else if (rd)    exp_rdata = model_load(rdat, off, n, uns);
    exp_stall = timed_out ? TO + 1 : ack_dly + 2;
    check("done_fault", fault, timed_out);
    check("done_req", bus_req, 0);
    check("done_stall", stall, 0);
    check("done_rdata", rdata, exp_rdata);
    check("stall_cycles", stall_cnt, exp_stall);
    tick();
    check("idle_fault", fault, 0);
    check("idle_rdata", rdata, exp_rdata);
  endtask

  initial begin
    int dly;
    logic [3:0] be;
    logic [31:0] a;
    bit rd, wr;
    rst_n = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
    idle_inputs();
    mem_read = 1'b1;
    #1;
    check("rst_stall", stall, 0);
    tick(); tick();
    check("rst_rdata", rdata, 0);
    check("rst_req", bus_req, 0);
    check("rst_addr", bus_addr, 0);
    check("rst_be", bus_be, 0);
    check("rst_wdata", bus_wdata, 0);
    check("rst_we", bus_we, 0);
    check("rst_mis", misaligned, 0);
    check("rst_fault", fault, 0);
    idle_inputs();
    rst_n = 1'b1;
    exp_rdata = '0;
    tick();

    // Signed byte load from the top lane, ack in the first BUS cycle.
    do_access(1, 0, 4'b0001, 0, 32'h0000_1003, 32'h0, 0, 32'h80FF_0000);
    check("byte_load", rdata, 32'hFFFF_FF80);
    // Half store to the upper lanes; rdata must keep the last load.
    do_access(0, 1, 4'b0011, 0, 32'h0000_2002, 32'h0000_BEEF, 2, 32'h1111_1111);
    check("half_store_rdata", rdata, 32'hFFFF_FF80);
    // Misaligned word load.
    do_access(1, 0, 4'b1111, 0, 32'h0000_3001, 32'h0, 0, 32'h0);
    // Unsigned then signed half load.
    do_access(1, 0, 4'b0011, 1, 32'h0000_0010, 32'h0, 1, 32'h1234_8001);
    check("half_u", rdata, 32'h0000_8001);
    do_access(1, 0, 4'b0011, 0, 32'h0000_0010, 32'h0, 0, 32'h1234_8001);
    check("half_s", rdata, 32'hFFFF_8001);
    // Ack on the last allowed cycle beats the timeout.
    do_access(1, 0, 4'b1111, 0, 32'h0000_0020, 32'h0, TO - 1, 32'hCAFE_F00D);
    check("ack_at_limit", rdata, 32'hCAFE_F00D);
    // No ack at all: timeout fault, rdata cleared.
    do_access(1, 0, 4'b1111, 0, 32'h0000_0024, 32'h0, 99, 32'h0);
    check("timeout_rdata", rdata, 32'h0);
    // Read wins over write; odd byte_en behaves as a word.
    do_access(1, 1, 4'b0011, 0, 32'h0000_0102, 32'hAAAA_5555, 0, 32'h7654_3210);
    do_access(1, 0, 4'b0101, 1, 32'h0000_0200, 32'h0, 1, 32'h8765_4321);
    check("odd_be_word", rdata, 32'h8765_4321);

    // Ack while idle is ignored.
    bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    tick();
    bus_ack = 1'b0;
    check("idle_ack_rdata", rdata, exp_rdata);
    check("idle_ack_req", bus_req, 0);

    // Reset in the middle of BUS, then a late ack.
    mem_read = 1'b1; byte_en = 4'b1111; addr = 32'h0000_0040;
    tick();
    idle_inputs();
    check("pre_rst_req", bus_req, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_stall", stall, 0);
    tick();
    check("rst_mid_req", bus_req, 0);
    check("rst_mid_rdata", rdata, 0);
    rst_n = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
    tick();
    bus_ack = 1'b0;
    exp_rdata = '0;
    check("late_ack_req", bus_req, 0);
    check("late_ack_rdata", rdata, 0);
    check("late_ack_stall", stall, 0);
    check("late_ack_fault", fault, 0);

    // Randomized accesses.
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 3))
        0: be = 4'b0001;
        1: be = 4'b0011;
        2: be = 4'b1111;
        default: be = 4'($urandom);
      endcase
      rd = 1'($urandom);
      wr = rd ? 1'($urandom) : 1'b1;
      a  = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = (size_bytes(be) == 4) ? 2'b00 :
                                               (size_bytes(be) == 2) ? {a[1], 1'b0} : a[1:0];
      dly = $urandom_range(0, TO + 1);
      do_access(rd, wr, be, 1'($urandom), a, $urandom, dly, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum bus wait cycles before a fault is declared.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  synchronous, active-low reset.
REQ-004 mem_read  in  1  load request from the decode stage.
REQ-005 mem_write  in  1  store request from the decode stage.
REQ-006 byte_en  in  4  access size: 0001 byte, 0011 half, 1111 word; any other value is treated as word.
REQ-007 us  in  1  unsigned load; zero-extend when 1, sign-extend when 0.
REQ-008 addr  in  32  byte address of the access.
REQ-009 wdata  in  32  store data, right-justified.
REQ-010 rdata  out  32  extended load result.
REQ-011 stall  out  1  holds the pipeline while an access is in flight.
REQ-012 misaligned  out  1  one-cycle pulse on a rejected unaligned access.
REQ-013 fault  out  1  one-cycle pulse on bus timeout.
REQ-014 bus_req, bus_we  out  1 each  bus request and write-enable.
REQ-015 bus_addr  out  32  word address, with bits [1:0] forced to 00.
REQ-016 bus_be  out  4  byte lanes to access.
REQ-017 bus_wdata  out  32  lane-aligned store data.
REQ-018 bus_rdata  in  32  read data; valid with bus_ack.
REQ-019 bus_ack  in  1  one-cycle completion strobe from the bus.

Function
REQ-020 The FSM SHALL have three states: IDLE, BUS, DONE.
REQ-021 Read priority: when mem_read and mem_write are both 1, the access is a read and mem_write is ignored.
REQ-022 Misalignment rules:
  - half access is misaligned when addr[0]=1;
  - word access is misaligned when addr[1:0]!=00;
  - byte access is never misaligned.
REQ-023 IDLE, request aligned:
  - register bus_addr, bus_be = byte_en<<addr[1:0], bus_wdata = wdata<<(8*addr[1:0]), bus_we, us and the lane offset;
  - go to BUS.
REQ-024 IDLE, request misaligned: pulse misaligned, make no bus access, stay in IDLE, stall=0.
REQ-025 BUS: bus_req=1 and all bus outputs SHALL hold stable.
  - On bus_ack, go to DONE.
  - For a read, capture the extended result into rdata at the same time.
REQ-026 Load extraction:
  - byte = bus_rdata[8*off+7 : 8*off];
  - half = bus_rdata[16*off[1]+15 : 16*off[1]];
  - word = bus_rdata unchanged;
  - sign- or zero-extend byte and half per us.
REQ-027 DONE: bus_req=0, stall=0, then go to IDLE unconditionally; a request is never accepted in DONE.
REQ-028 Stall: stall = (IDLE and aligned request) or BUS; it is combinational in IDLE and 0 in DONE.
REQ-029 Latency: the pipeline is released in the cycle after bus_ack; minimum stall is 2 cycles (ack in the first BUS cycle).
REQ-030 A wait counter SHALL clear on entering BUS and increment each BUS cycle without ack.
  - When it reaches TIMEOUT, go to DONE, pulse fault, and set rdata=0.
  - bus_ack in the same cycle as the timeout wins; no fault is raised.
REQ-031 bus_ack outside BUS SHALL be ignored.
REQ-032 A store SHALL NOT modify rdata; rdata holds the last load result.

Reset
REQ-033 With rst_n=0 at a clock edge, the block SHALL reset as follows:
  - state = IDLE;
  - rdata, bus_addr, bus_be, bus_wdata = 0;
  - bus_req, bus_we, misaligned, fault, wait counter = 0.
REQ-034 Reset during BUS SHALL drop bus_req in the next cycle with no DONE cycle; a late ack is then ignored.
REQ-035 stall SHALL be 0 while rst_n=0.

Verification
REQ-036 Signed byte load: addr=0x1003, byte_en=0001, us=0, ack on the first BUS cycle with bus_rdata=0x80FF_0000 -> bus_addr=0x1000, bus_be=1000, rdata=0xFFFF_FF80, stall high exactly 2 cycles.
REQ-037 Half store: addr=0x2002, byte_en=0011, wdata=0x0000_BEEF, ack after 3 cycles -> bus_we=1, bus_be=1100, bus_wdata=0xBEEF_0000, stable through BUS, rdata unchanged.
REQ-038 Misaligned word load: addr=0x3001, byte_en=1111 -> misaligned pulses for 1 cycle, bus_req never rises, stall=0.
REQ-039 Timeout: TIMEOUT=4, no ack -> fault pulses after 4 BUS cycles, rdata=0, FSM returns to IDLE.
REQ-040 Reset mid-BUS, then ack -> bus_req low, state IDLE, rdata=0.
REQ-041 Unsigned half load: addr=0x10, us=1, bus_rdata=0x1234_8001 -> rdata=0x0000_8001; the same load with us=0 -> rdata=0xFFFF_8001.
